irom_loader: RTL and testbench

- Streams a program image into the CPU instruction memory and holds the core disabled until the image is complete and verified.
- Accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words and issues one write per word to the IROM write port.
- Drives the core's en_in through cpu_en, releasing it only after a good checksum.
- The IROM is the reader of instruction words; this block is the writer.

---
 rtl/irom_loader.sv | 136 +++++++++++++
 tb/tb_irom_loader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irom_loader.sv
// Program-image loader for the CPU instruction ROM: parses a length-prefixed,
// XOR-checksummed byte stream into 16-bit words and releases the core on success.
module irom_loader #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [AWIDTH-1:0] wr_addr,
    output logic [DWIDTH-1:0] wr_data,
    output logic              cpu_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN_H = 3'd1;
    localparam logic [2:0] S_LEN_L = 3'd2;
    localparam logic [2:0] S_DAT_H = 3'd3;
    localparam logic [2:0] S_DAT_L = 3'd4;
    localparam logic [2:0] S_CHK   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    // Largest legal word count: a full IROM, so addresses never wrap.
    localparam logic [16:0] MAX_WORDS = 17'(1) << AWIDTH;

    logic [2:0]        state;
    logic [7:0]        len_h;
    logic [15:0]       len;
    logic [7:0]        hi_byte;
    logic [7:0]        chk;
    logic [AWIDTH:0]   cnt;
    logic [16:0]       cnt_nxt;
    logic [16:0]       len_in;
    logic              xfer;

    assign in_ready = (state == S_LEN_H) || (state == S_LEN_L) || (state == S_DAT_H) ||
                      (state == S_DAT_L) || (state == S_CHK);
    assign xfer     = in_valid & in_ready;
    assign cnt_nxt  = 17'(cnt) + 17'd1;
    assign len_in   = {1'b0, len_h, in_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            len_h   <= '0;
            len     <= '0;
            hi_byte <= '0;
            chk     <= '0;
            cnt     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            cpu_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state  <= S_LEN_H;
                        done   <= 1'b0;
                        err    <= 1'b0;
                        cpu_en <= 1'b0;
                        chk    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                    end
                end
                S_LEN_H: begin
                    if (xfer) begin
                        len_h <= in_data;
                        chk   <= chk ^ in_data;
                        state <= S_LEN_L;
                    end
                end
                S_LEN_L: begin
                    if (xfer) begin
                        len <= len_in[15:0];
                        chk <= chk ^ in_data;
                        if (len_in > MAX_WORDS) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end else if (len_in == 17'd0) begin
                            state <= S_CHK;
                        end else begin
                            state <= S_DAT_H;
                        end
                    end
                end
                S_DAT_H: begin
                    if (xfer) begin
                        hi_byte <= in_data;
                        chk     <= chk ^ in_data;
                        state   <= S_DAT_L;
                    end
                end
                S_DAT_L: begin
                    if (xfer) begin
                        wr_en   <= 1'b1;
                        wr_data <= DWIDTH'({hi_byte, in_data});
                        wr_addr <= cnt[AWIDTH-1:0];
                        cnt     <= cnt_nxt[AWIDTH:0];
                        chk     <= chk ^ in_data;
                        state   <= (cnt_nxt < {1'b0, len}) ? S_DAT_H : S_CHK;
                    end
                end
                S_CHK: begin
                    if (xfer) begin
                        busy <= 1'b0;
                        if (in_data == chk) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            cpu_en <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irom_loader.sv
// Randomized self-checking bench for irom_loader against a stream-level model.
module tb_irom_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, wr_en, cpu_en, busy, done, err;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;

    int checks = 0;
    int errors = 0;

    logic [7:0]  img[$];
    logic [27:0] obs[$];
    logic [27:0] exp_w[$];
    bit          exp_done, exp_err;
    int          exp_cons;

    irom_loader #(.DWIDTH(16), .AWIDTH(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_en(cpu_en), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_en) obs.push_back({wr_addr, wr_data});

    // Reference: interpret the byte image directly from the stream format.
    task automatic model();
        int n;
        logic [7:0] x;
        exp_w.delete();
        n = int'(img[0]) * 256 + int'(img[1]);
        if (n > 4096) begin
            exp_err = 1; exp_done = 0; exp_cons = 2;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < 2 + 2 * n; i++) x = x ^ img[i];
        for (int i = 0; i < n; i++) exp_w.push_back({12'(i), img[2 + 2 * i], img[3 + 2 * i]});
        exp_cons = 3 + 2 * n;
        exp_done = (img[2 + 2 * n] == x);
        exp_err  = !exp_done;
    endtask

    task automatic build(input int n, input bit bad);
        logic [7:0] x, b;
        img.delete();
        img.push_back(8'(n >> 8));
        img.push_back(8'(n & 255));
        for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom);
            img.push_back(b);
        end
        x = 8'h00;
        foreach (img[i]) x = x ^ img[i];
        img.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b;
            if (in_ready) begin
                @(posedge clk);
                ok = 1;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Sends bytes [from, to) with gaps of gmin..gmax idle cycles between them.
    task automatic drive(input int from, input int to, input int gmin, input int gmax);
        bit ok;
        for (int i = from; i < to; i++) begin
            send_byte(img[i], ok);
            if (!ok) begin
                checks++; errors++;
                $display("FAIL handshake_timeout byte %0d: in_ready never rose", i);
                break;
            end
            if (gmax > 0 && i != to - 1) idle($urandom_range(gmin, gmax));
        end
        idle(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, wr_en, wr_addr, wr_data, cpu_en, busy, done, err} !== 34'd0) begin
            errors++;
            $display("FAIL reset_state got %h want 0",
                     {in_ready, wr_en, wr_addr, wr_data, cpu_en, busy, done, err});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_program();
        img = '{8'h00, 8'h02, 8'h41, 8'h00, 8'h10, 8'h00, 8'h53};
        model();
        obs.delete();
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL load_busy got %b want 1", busy); end
        drive(0, exp_cons, 0, 0);
        checks++;
        if (obs !== exp_w) begin errors++; $display("FAIL load_writes got %p want %p", obs, exp_w); end
        checks++;
        if ({done, err, cpu_en, busy} !== 4'b1010)
            begin errors++; $display("FAIL load_status got %b want 1010", {done, err, cpu_en, busy}); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL load_ready_in_done got %b want 0", in_ready); end
    endtask

    task automatic test_backpressure();
        img = '{8'h00, 8'h02, 8'h41, 8'h00, 8'h10, 8'h00, 8'h53};
        model();
        obs.delete();
        pulse_start();
        drive(0, exp_cons, 3, 3);
        checks++;
        if (obs !== exp_w) begin errors++; $display("FAIL bp_writes got %p want %p", obs, exp_w); end
        checks++;
        if ({done, err, cpu_en, busy} !== 4'b1010)
            begin errors++; $display("FAIL bp_status got %b want 1010", {done, err, cpu_en, busy}); end
    endtask

    task automatic test_bad_checksum();
        img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
        model();
        obs.delete();
        pulse_start();
        drive(0, exp_cons, 0, 1);
        checks++;
        if (obs !== exp_w) begin errors++; $display("FAIL badchk_writes got %p want %p", obs, exp_w); end
        checks++;
        if ({done, err, cpu_en, busy} !== 4'b0100)
            begin errors++; $display("FAIL badchk_status got %b want 0100", {done, err, cpu_en, busy}); end
    endtask

    task automatic test_length_error();
        img = '{8'h10, 8'h01};
        model();
        obs.delete();
        pulse_start();
        drive(0, exp_cons, 0, 0);
        checks++;
        if (obs.size() !== 0) begin errors++; $display("FAIL lenerr_writes got %0d want 0", obs.size()); end
        checks++;
        if ({done, err, cpu_en, busy, in_ready} !== 5'b01000)
            begin errors++; $display("FAIL lenerr_status got %b want 01000", {done, err, cpu_en, busy, in_ready}); end
    endtask

    task automatic test_zero_length();
        img = '{8'h00, 8'h00, 8'h00};
        model();
        obs.delete();
        pulse_start();
        drive(0, exp_cons, 0, 2);
        checks++;
        if (obs.size() !== 0) begin errors++; $display("FAIL zero_writes got %0d want 0", obs.size()); end
        checks++;
        if ({done, err, cpu_en, busy} !== 4'b1010)
            begin errors++; $display("FAIL zero_status got %b want 1010", {done, err, cpu_en, busy}); end
    endtask

    task automatic test_max_length();
        build(4096, 0);
        model();
        obs.delete();
        pulse_start();
        drive(0, exp_cons, 0, 0);
        checks++;
        if (obs !== exp_w) begin errors++; $display("FAIL max_writes got %0d words want %0d", obs.size(), exp_w.size()); end
        checks++;
        if (obs.size() == 0 || obs[obs.size() - 1][27:16] !== 12'hfff)
            begin errors++; $display("FAIL max_last_addr got %0d words want last addr fff", obs.size()); end
        checks++;
        if ({done, err, cpu_en, busy} !== 4'b1010)
            begin errors++; $display("FAIL max_status got %b want 1010", {done, err, cpu_en, busy}); end
    endtask

    task automatic test_reset_midload();
        build(5, 0);
        model();
        obs.delete();
        pulse_start();
        drive(0, 9, 0, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = img[9];
        rst_n    = 1'b0;
        #1;
        checks++;
        if ({in_ready, wr_en, wr_addr, wr_data, cpu_en, busy, done, err} !== 34'd0) begin
            errors++;
            $display("FAIL midreset_outputs got %h want 0",
                     {in_ready, wr_en, wr_addr, wr_data, cpu_en, busy, done, err});
        end
        checks++;
        if (obs.size() !== 3) begin errors++; $display("FAIL midreset_prewrites got %0d want 3", obs.size()); end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        build($urandom_range(1, 8), 0);
        model();
        obs.delete();
        pulse_start();
        drive(0, exp_cons, 0, 2);
        checks++;
        if (obs !== exp_w) begin errors++; $display("FAIL midreset_writes got %p want %p", obs, exp_w); end
        checks++;
        if ({done, err, cpu_en, busy} !== 4'b1010)
            begin errors++; $display("FAIL midreset_status got %b want 1010", {done, err, cpu_en, busy}); end
    endtask

    task automatic test_start_while_busy();
        build(4, 0);
        model();
        obs.delete();
        pulse_start();
        drive(0, 5, 0, 0);
        pulse_start();
        drive(5, exp_cons, 0, 1);
        checks++;
        if (obs !== exp_w) begin errors++; $display("FAIL busystart_writes got %p want %p", obs, exp_w); end
        checks++;
        if ({done, err, cpu_en, busy} !== 4'b1010)
            begin errors++; $display("FAIL busystart_status got %b want 1010", {done, err, cpu_en, busy}); end
    endtask

    // start coincides with a valid byte while in DONE: that byte must not be consumed.
    task automatic test_back_to_back();
        build(3, 0);
        model();
        obs.delete();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = img[0];
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({busy, done, cpu_en} !== 3'b100)
            begin errors++; $display("FAIL b2b_restart got %b want 100", {busy, done, cpu_en}); end
        drive(0, exp_cons, 0, 0);
        checks++;
        if (obs !== exp_w) begin errors++; $display("FAIL b2b_writes got %p want %p", obs, exp_w); end
        checks++;
        if ({done, err, cpu_en, busy} !== 4'b1010)
            begin errors++; $display("FAIL b2b_status got %b want 1010", {done, err, cpu_en, busy}); end
    endtask

    task automatic test_random();
        logic [3:0] want;
        for (int k = 0; k < 8; k++) begin
            build($urandom_range(0, 24), ($urandom_range(0, 2) == 0));
            model();
            obs.delete();
            pulse_start();
            drive(0, exp_cons, 0, 3);
            want = exp_done ? 4'b1010 : 4'b0100;
            checks++;
            if (obs !== exp_w) begin errors++; $display("FAIL rand%0d_writes got %p want %p", k, obs, exp_w); end
            checks++;
            if ({done, err, cpu_en, busy} !== want)
                begin errors++; $display("FAIL rand%0d_status got %b want %b", k, {done, err, cpu_en, busy}, want); end
        end
    endtask

    initial begin
        test_reset();
        test_load_program();
        test_back_to_back();
        test_backpressure();
        test_bad_checksum();
        test_length_error();
        test_zero_length();
        test_max_length();
        test_reset_midload();
        test_start_while_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
